// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: re-encodes control-signal bundles into 16-bit
// instruction words and streams them into instruction memory.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   start, base_addr       begin a load session at base_addr (IDLE only)
//   in_valid/in_ready      input bundle handshake, in_last marks final bundle
//   in_reg_write .. in_branch, in_alu_op, in_rd, in_rs1, in_rs2_imm
//                          control bundle and register/immediate fields
//   imem_we/addr/wdata     instruction-memory write port, imem_ready backpressure
//   busy, done             session status; done pulses on the final cycle
//   err_illegal, err_count illegal bundle pulse and saturating session count
//   word_count             words written this session
module instr_encoder_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              in_reg_write,
  input  logic              in_mem_write,
  input  logic              in_alu_src,
  input  logic              in_mem_to_reg,
  input  logic              in_branch,
  input  logic [2:0]        in_alu_op,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [7:0]        err_count,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                err_illegal_q, err_illegal_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]   mem_d [FIFO_DEPTH];

  logic [4:0]          ctrl_c;
  logic                legal_c;
  logic [3:0]          opcode_c;
  logic [WORD_W-1:0]   enc_word_c;
  logic                fifo_full_c, fifo_empty_c;
  logic                accept_c, push_c, pop_c;

  // Opcode recovery from the control bundle; NOP carries all-zero fields.
  always_comb begin
    ctrl_c     = {in_reg_write, in_mem_write, in_alu_src, in_mem_to_reg, in_branch};
    legal_c    = 1'b0;
    opcode_c   = 4'h0;
    enc_word_c = '0;
    unique case (ctrl_c)
      5'b10000: if (!in_alu_op[2])         begin legal_c = 1'b1; opcode_c = {1'b0, in_alu_op}; end
      5'b10110: if (in_alu_op == 3'b000)   begin legal_c = 1'b1; opcode_c = 4'h4; end
      5'b01100: if (in_alu_op == 3'b000)   begin legal_c = 1'b1; opcode_c = 4'h5; end
      5'b00001: if (in_alu_op == 3'b001)   begin legal_c = 1'b1; opcode_c = 4'h6; end
      5'b00000: if (in_alu_op == 3'b000)   begin legal_c = 1'b1; opcode_c = 4'h7; end
      default: ;
    endcase
    if (opcode_c == 4'h7) begin
      enc_word_c = {4'h7, 12'h000};
    end else begin
      enc_word_c = {opcode_c, in_rd, in_rs1, in_rs2_imm};
    end
  end

  // Handshakes: in_ready only depends on flops, write strobe follows memory ready.
  always_comb begin
    fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty_c = (count_q == '0);
    in_ready     = (state_q == S_LOAD) && !fifo_full_c;
    accept_c     = in_valid && in_ready;
    push_c       = accept_c && legal_c;
    pop_c        = !fifo_empty_c && imem_ready;
    imem_we      = pop_c;
    imem_wdata   = mem_q[rd_ptr_q];
    imem_addr    = addr_q;
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DRAIN) && fifo_empty_c;
    err_illegal  = err_illegal_q;
    err_count    = err_count_q;
    word_count   = word_count_q;
  end

  // Next-state: session FSM, counters, FIFO bookkeeping.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    err_count_d   = err_count_q;
    word_count_d  = word_count_q;
    err_illegal_d = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mem_d         = mem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          err_count_d  = '0;
          word_count_d = '0;
        end
      end
      S_LOAD: begin
        if (accept_c && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept_c && !legal_c) begin
      err_illegal_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = enc_word_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop_c) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      addr_d       = addr_q + ADDR_W'(1);
      word_count_d = word_count_q + (ADDR_W + 1)'(1);
    end

    // Start is only honoured in IDLE where the FIFO is empty, so no pop competes.
    if (state_q == S_IDLE && start) addr_d = base_addr;

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      err_count_q   <= '0;
      word_count_q  <= '0;
      err_illegal_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mem_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      err_count_q   <= err_count_d;
      word_count_q  <= word_count_d;
      err_illegal_q <= err_illegal_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        in_reg_write, in_mem_write, in_alu_src, in_mem_to_reg, in_branch;
  logic [2:0]  in_alu_op;
  logic [3:0]  in_rd, in_rs1, in_rs2_imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        imem_ready;
  logic        busy, done, err_illegal;
  logic [7:0]  err_count;
  logic [8:0]  word_count;

  int checks;
  int errors;
  int err_pulses;
  int done_pulses;
  int lb;
  int eb;
  int db;
  logic [23:0] wlog[$];
  logic [23:0] wexp[$];

  instr_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_reg_write (in_reg_write),
    .in_mem_write (in_mem_write),
    .in_alu_src   (in_alu_src),
    .in_mem_to_reg(in_mem_to_reg),
    .in_branch    (in_branch),
    .in_alu_op    (in_alu_op),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2_imm   (in_rs2_imm),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .imem_ready   (imem_ready),
    .busy         (busy),
    .done         (done),
    .err_illegal  (err_illegal),
    .err_count    (err_count),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle observer of the write port and pulse outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we) wlog.push_back({imem_addr, imem_wdata});
      if (err_illegal) err_pulses++;
      if (done) done_pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
    eb = err_pulses;
    db = done_pulses;
  endtask

  task automatic drive(input logic [4:0] ctrl, input logic [2:0] op,
                       input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic last);
    {in_reg_write, in_mem_write, in_alu_src, in_mem_to_reg, in_branch} = ctrl;
    in_alu_op  = op;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2_imm = rs2;
    in_last    = last;
    in_valid   = 1'b1;
  endtask

  task automatic send(input logic [4:0] ctrl, input logic [2:0] op,
                      input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic last);
    logic acc;
    acc = 1'b0;
    drive(ctrl, op, rd, rs1, rs2, last);
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    tick();
    check(tag, 32'(seen), 32'd1);
    check({tag, "_pulses"}, 32'(done_pulses - db), 32'd1);
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_nwrites"}, 32'(wlog.size() - lb), 32'(wexp.size()));
    for (int i = 0; i < wexp.size(); i++) begin
      if (lb + i < wlog.size()) check(tag, 32'(wlog[lb + i]), 32'(wexp[i]));
    end
    wexp.delete();
    lb = wlog.size();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    32'(in_ready),    32'd0);
    check({tag, "_imem_we"},     32'(imem_we),     32'd0);
    check({tag, "_imem_addr"},   32'(imem_addr),   32'd0);
    check({tag, "_imem_wdata"},  32'(imem_wdata),  32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_err_illegal"}, 32'(err_illegal), 32'd0);
    check({tag, "_err_count"},   32'(err_count),   32'd0);
    check({tag, "_word_count"},  32'(word_count),  32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; err_pulses = 0; done_pulses = 0;
    lb = 0; eb = 0; db = 0;
    rst_n = 1'b1; start = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_last = 1'b0;
    {in_reg_write, in_mem_write, in_alu_src, in_mem_to_reg, in_branch} = 5'b0;
    in_alu_op = '0; in_rd = '0; in_rs1 = '0; in_rs2_imm = '0;
    imem_ready = 1'b1;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single ADD at 0x10
    do_start(8'h10);
    check("t1_busy", 32'(busy), 32'd1);
    send(5'b10000, 3'b000, 4'h1, 4'h2, 4'h3, 1'b1);
    wexp.push_back({8'h10, 16'h0123});
    wait_done("t1_done");
    cmp_writes("t1_wr");
    check("t1_word_count", 32'(word_count), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // LOAD / STORE / BEQ from 0x00
    do_start(8'h00);
    send(5'b10110, 3'b000, 4'h5, 4'h2, 4'h4, 1'b0);
    send(5'b01100, 3'b000, 4'h3, 4'h1, 4'h7, 1'b0);
    send(5'b00001, 3'b001, 4'h1, 4'h2, 4'hF, 1'b1);
    wexp.push_back({8'h00, 16'h4524});
    wexp.push_back({8'h01, 16'h5317});
    wexp.push_back({8'h02, 16'h612F});
    wait_done("t2_done");
    cmp_writes("t2_wr");
    check("t2_word_count", 32'(word_count), 32'd3);
    check("t2_err_count", 32'(err_count), 32'd0);

    // Illegal bundle sandwiched between ADD and SUB
    do_start(8'h20);
    send(5'b10000, 3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
    send(5'b11000, 3'b000, 4'h9, 4'h9, 4'h9, 1'b0);
    send(5'b10000, 3'b001, 4'h4, 4'h5, 4'h6, 1'b1);
    wexp.push_back({8'h20, 16'h0123});
    wexp.push_back({8'h21, 16'h1456});
    wait_done("t3_done");
    cmp_writes("t3_wr");
    check("t3_err_pulses", 32'(err_pulses - eb), 32'd1);
    check("t3_err_count", 32'(err_count), 32'd1);
    check("t3_word_count", 32'(word_count), 32'd2);

    // Backpressure: FIFO fills at four, two more flow after release
    imem_ready = 1'b0;
    do_start(8'h30);
    check("t4_err_count_clr", 32'(err_count), 32'd0);
    send(5'b10000, 3'b000, 4'h1, 4'h1, 4'h1, 1'b0);
    send(5'b10000, 3'b001, 4'h2, 4'h2, 4'h2, 1'b0);
    send(5'b10000, 3'b010, 4'h3, 4'h3, 4'h3, 1'b0);
    send(5'b10000, 3'b011, 4'h4, 4'h4, 4'h4, 1'b0);
    drive(5'b10110, 3'b000, 4'h5, 4'h5, 4'h5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_full_in_ready", 32'(in_ready), 32'd0);
      check("t4_held_we", 32'(imem_we), 32'd0);
      tick();
    end
    imem_ready = 1'b1;
    send(5'b10110, 3'b000, 4'h5, 4'h5, 4'h5, 1'b0);
    send(5'b01100, 3'b000, 4'h6, 4'h6, 4'h6, 1'b1);
    wexp.push_back({8'h30, 16'h0111});
    wexp.push_back({8'h31, 16'h1222});
    wexp.push_back({8'h32, 16'h2333});
    wexp.push_back({8'h33, 16'h3444});
    wexp.push_back({8'h34, 16'h4555});
    wexp.push_back({8'h35, 16'h5666});
    wait_done("t4_done");
    cmp_writes("t4_wr");
    check("t4_word_count", 32'(word_count), 32'd6);

    // Address wrap 0xFE -> 0x00, NOP fields cleared
    do_start(8'hFE);
    send(5'b00000, 3'b000, 4'h9, 4'h9, 4'h9, 1'b0);
    send(5'b10000, 3'b011, 4'hA, 4'hB, 4'hC, 1'b0);
    send(5'b10000, 3'b010, 4'h1, 4'h1, 4'h1, 1'b1);
    wexp.push_back({8'hFE, 16'h7000});
    wexp.push_back({8'hFF, 16'h3ABC});
    wexp.push_back({8'h00, 16'h2111});
    wait_done("t5_done");
    cmp_writes("t5_wr");
    check("t5_word_count", 32'(word_count), 32'd3);
    check("t5_next_addr", 32'(imem_addr), 32'd1);

    // Reset with three words buffered
    imem_ready = 1'b0;
    do_start(8'h40);
    send(5'b10000, 3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
    send(5'b10000, 3'b001, 4'h4, 4'h5, 4'h6, 1'b0);
    send(5'b11111, 3'b111, 4'h0, 4'h0, 4'h0, 1'b0);
    send(5'b10000, 3'b010, 4'h7, 4'h8, 4'h9, 1'b0);
    check("t6_pre_busy", 32'(busy), 32'd1);
    check("t6_pre_err_count", 32'(err_count), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_rst");
    imem_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    cmp_writes("t6_after_rst");
    check("t6_idle_busy", 32'(busy), 32'd0);

    do_start(8'h50);
    send(5'b10000, 3'b000, 4'h7, 4'h8, 4'h9, 1'b1);
    wexp.push_back({8'h50, 16'h0789});
    wait_done("t6_done");
    cmp_writes("t6_wr");
    check("t6_word_count", 32'(word_count), 32'd1);
    check("t6_err_count", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
